// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM control unit for the multicycle ARM-subset core
// Ports:
//   clk, reset (sync, active-low)
//   cond/op/funct/rd : instruction fields from the IR
//   alu_flags        : NZCV produced by the ALU this cycle
//   pc_write, ir_write, mem_write, reg_write : architectural write enables
//   adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src, reg_src : datapath selects
//   state            : current FSM state (debug)
//   flags            : architectural NZCV register
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] state,
    output logic [3:0] flags
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;
    state_t     r_state, w_st, w_next;
    logic [3:0] r_flags;
    logic       r_cond_ex, w_cond_ex, w_c;
    logic [1:0] w_alu;
    logic       w_wr, w_valid, w_arith, w_pc, w_ir, w_mw, w_rw;
    logic [3:0] w_cmd;
    assign w_cmd   = funct[4:1];
    assign w_st    = reset ? r_state : FETCH;
    assign state   = w_st;
    assign flags   = r_flags;
    assign imm_src = op;
    assign reg_src = {op == 2'b01, op == 2'b10};
    always_comb begin
        case (cond[3:1])
            3'b000:  w_c = r_flags[2];
            3'b001:  w_c = r_flags[1];
            3'b010:  w_c = r_flags[3];
            3'b011:  w_c = r_flags[0];
            3'b100:  w_c = r_flags[1] & ~r_flags[2];
            3'b101:  w_c = r_flags[3] == r_flags[0];
            3'b110:  w_c = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            default: w_c = 1'b1;
        endcase
        // odd codes invert their even partner; 1111 is "never"
        w_cond_ex = (cond[3:1] == 3'b111) ? ~cond[0] : w_c ^ cond[0];
    end
    always_comb begin
        w_alu   = 2'b00;
        w_wr    = 1'b1;
        w_valid = 1'b1;
        w_arith = 1'b1;
        case (w_cmd)
            4'b0100: w_alu = 2'b00;
            4'b0010: w_alu = 2'b01;
            4'b0000: begin w_alu = 2'b10; w_arith = 1'b0; end
            4'b1100: begin w_alu = 2'b11; w_arith = 1'b0; end
            4'b1010: begin w_alu = 2'b01; w_wr = 1'b0; end
            default: begin w_wr = 1'b0; w_valid = 1'b0; w_arith = 1'b0; end
        endcase
    end
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE:  w_next = (op == 2'b00) ? (funct[5] ? EXECI : EXECR) :
                              (op == 2'b01) ? MEMADR :
                              (op == 2'b10) ? BRANCH : FETCH;
            MEMADR:  w_next = funct[0] ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            EXECR:   w_next = ALUWB;
            EXECI:   w_next = ALUWB;
            default: w_next = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            r_state   <= w_next;
            // ALUWB gates with the condition as seen in EXECR, before its own flag write
            r_cond_ex <= w_cond_ex;
            if ((r_state == EXECR || r_state == EXECI) && w_cond_ex && w_valid &&
                (funct[0] || w_cmd == 4'b1010)) begin
                r_flags[3:2] <= alu_flags[3:2];
                if (w_arith)
                    r_flags[1:0] <= alu_flags[1:0];
            end
        end
    end
    always_comb begin
        w_pc        = 1'b0;
        w_ir        = 1'b0;
        w_mw        = 1'b0;
        w_rw        = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 2'b00;
        case (w_st)
            FETCH: begin
                w_ir       = 1'b1;
                w_pc       = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWR: begin
                adr_src = 1'b1;
                w_mw    = w_cond_ex;
            end
            MEMWB: begin
                result_src = 2'b01;
                w_rw       = w_cond_ex;
                w_pc       = w_cond_ex & (rd == 4'd15);
            end
            EXECR:  alu_control = w_alu;
            EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = w_alu;
            end
            ALUWB: begin
                w_rw = r_cond_ex & w_wr;
                w_pc = r_cond_ex & w_wr & (rd == 4'd15);
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                w_pc       = w_cond_ex;
            end
            default: ;
        endcase
    end
    assign pc_write  = reset & w_pc;
    assign ir_write  = reset & w_ir;
    assign mem_write = reset & w_mw;
    assign reg_write = reset & w_rw;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the ARM-subset processor core. It decodes the instruction-register fields the datapath exposes (`cond`, `op`, `funct`, `rd`), holds the NZCV status flags, and evaluates condition codes. It sequences a shared-memory multicycle datapath through fetch, decode, execute, memory and writeback by driving every mux select and write enable each cycle. It replaces the single-cycle combinational decoder and owns all architectural-state write gating.

## Interface

Parameters:
- none (state encoding and ISA subset are fixed)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `cond`  in  4  instr[31:28], stable from the cycle after FETCH until the next FETCH
- `op`  in  2  instr[27:26]
- `funct`  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (data processing) or L (memory)
- `rd`  in  4  instr[15:12]
- `alu_flags`  in  4  NZCV from ALU, current cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address: 0=PC, 1=ALUOut register
- `ir_write`  out  1  instruction register enable
- `mem_write`  out  1  memory write enable
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result direct
- `alu_src_a`  out  1  0=rd1, 1=PC
- `alu_src_b`  out  2  00=rd2, 01=ext_imm, 10=constant 4
- `alu_control`  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- `imm_src`  out  2  always equal to `op`
- `reg_src`  out  2  [0]=(op==10), [1]=(op==01); combinational from `op`
- `state`  out  4  current FSM state, for debug and verification
- `flags`  out  4  architectural NZCV register

## Operation

- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are unreachable and go to FETCH next cycle.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op=00 & funct[5]=0 → EXECR; op=00 & funct[5]=1 → EXECI; op=01 → MEMADR; op=10 → BRANCH; op=11 → FETCH (no-op).
  - MEMADR → MEMRD if funct[0]=1, else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH; EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- Per-state outputs (any output not listed is 0):
  - FETCH: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=10, alu_control=00, result_src=10.
  - DECODE: alu_src_a=1, alu_src_b=10, alu_control=00, result_src=10.
  - MEMADR: alu_src_b=01, alu_control=00.
  - MEMRD: adr_src=1.
  - MEMWR: adr_src=1, mem_write=cond_ex.
  - MEMWB: result_src=01, reg_write=cond_ex, pc_write=cond_ex & rd==15.
  - EXECR: alu_src_b=00, alu_control=decoded.
  - EXECI: alu_src_b=01, alu_control=decoded.
  - ALUWB: result_src=00, reg_write=cond_ex & wr, pc_write=cond_ex & wr & rd==15.
  - BRANCH: alu_src_b=01, alu_control=00, result_src=10, pc_write=cond_ex.
- cmd decode:
  - 0100 → ADD, wr=1.
  - 0010 → SUB, wr=1.
  - 0000 → AND, wr=1.
  - 1100 → ORR, wr=1.
  - 1010 (CMP) → SUB, wr=0.
  - Any other cmd → alu_control=00, wr=0, no flag update.
- Flag update: at the end of EXECR/EXECI, when cond_ex is true and (funct[0]=1 or cmd=CMP):
  - NZ is always written.
  - CV is written only for ADD, SUB and CMP.
  - Bits not written hold their value.
- cond_ex is evaluated against the `flags` register (the value before any update), never against `alu_flags`:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - 1110 (AL) → 1; 1111 → 0.

## Timing

- While reset=0 at a rising edge: state←FETCH and flags←0000.
- While reset=0, pc_write, ir_write, mem_write and reg_write are forced to 0. All other outputs follow state FETCH.
- Reset asserted mid-instruction aborts it: no further writes, and the next fetch begins on the first edge with reset=1.
- All outputs are combinational from `state`, the instruction fields and `flags`; there are no output registers.
- Instruction latency in cycles, FETCH inclusive:
  - data processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - op=11: 2
- A failed condition still traverses the full state path with its writes suppressed, so latency is independent of the condition outcome.
- A flags write in EXECR/EXECI is visible to cond_ex from the following cycle (ALUWB) onward. The instruction's own ALUWB gating must use its own cond_ex, so the evaluation is registered at EXECR/EXECI entry or the pre-update flags are kept.

## Test plan

- Reset: hold reset=0 for 3 cycles, then release → state=0, flags=0000, all write enables 0 during reset; ir_write=1 and pc_write=1 in the first cycle after release.
- ADDS, cond=AL, cmd=0100, S=1, with alu_flags=0110 in EXECR → states 0,1,6,8,0; flags=0110 after EXECR; reg_write=1 only in ALUWB.
- CMP then BEQ, with CMP alu_flags=0100 → flags=0100; BEQ visits states 0,1,9 with pc_write=1 in BRANCH. Repeat with flags=0000 → pc_write=0 in BRANCH.
- LDR with rd=15, cond=AL → states 0,1,2,3,4; adr_src=1 in MEMRD; MEMWB has result_src=01, reg_write=1, pc_write=1.
- STR with cond=NE while Z=1 → states 0,1,2,5,0 with mem_write=0 throughout.
- ORR with S=1 under a failing condition → flags unchanged and reg_write=0. Drive op=11 → states 0,1,0. Assert reset=0 while in MEMWR → mem_write=0 that cycle and state=0 on the next edge.
